// File: rtl/stream_demux_pkg.sv
// Shared types and channel indices for the 1-to-2 stream demultiplexer.
package stream_demux_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ROUTE = 1'b1
   } state_e;

   localparam int NUM_CH = 2;
   localparam int CH_Y0  = 0;
   localparam int CH_Y1  = 1;

endpackage

// File: rtl/stream_demux_slot.sv
// One-entry output register with valid/last; can_load tells the producer side
// whether a beat may be written this cycle (empty, or draining in the same cycle).
module stream_demux_slot #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             d_last,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   output logic             q_last,
   input  logic             q_ready,
   output logic             can_load
);

   assign can_load = !q_valid || q_ready;

   // load wins over drain, so a simultaneous drain+load keeps the slot full
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q       <= '0;
         q_valid <= 1'b0;
         q_last  <= 1'b0;
      end else if (load) begin
         q       <= d;
         q_last  <= d_last;
         q_valid <= 1'b1;
      end else if (q_valid && q_ready) begin
         q_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-2 stream demux: select sampled on a packet's first beat and
// locked until its last beat. Optional beat counters under STREAM_DEMUX_STATS_EN.
module stream_demux
   import stream_demux_pkg::*;
#(
   parameter int WIDTH = 1
`ifdef STREAM_DEMUX_STATS_EN
   ,parameter int CNT_W = 16
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic             a_valid,
   input  logic             a_last,
   output logic             a_ready,
   input  logic             s,
   output logic [WIDTH-1:0] y0,
   output logic             y0_valid,
   output logic             y0_last,
   input  logic             y0_ready,
   output logic [WIDTH-1:0] y1,
   output logic             y1_valid,
   output logic             y1_last,
   input  logic             y1_ready,
   output logic             busy
`ifdef STREAM_DEMUX_STATS_EN
   ,output logic [CNT_W-1:0] cnt0
   ,output logic [CNT_W-1:0] cnt1
`endif
);

   state_e                         state_q, state_d;
   logic                           sel_q, sel_d;
   logic                           target;
   logic                           accept;
   logic [NUM_CH-1:0]              load;
   logic [NUM_CH-1:0]              can_load;
   logic [NUM_CH-1:0]              yv;
   logic [NUM_CH-1:0]              yl;
   logic [NUM_CH-1:0]              yr;
   logic [NUM_CH-1:0][WIDTH-1:0]   yd;

   // only the target channel gates a_ready; the other channel never stalls input
   assign target        = (state_q == ST_IDLE) ? s : sel_q;
   assign a_ready       = can_load[target];
   assign accept        = a_valid && a_ready;
   assign load[CH_Y0]   = accept && !target;
   assign load[CH_Y1]   = accept && target;
   assign yr[CH_Y0]     = y0_ready;
   assign yr[CH_Y1]     = y1_ready;
   assign busy          = (state_q == ST_ROUTE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sel_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      case (state_q)
         ST_IDLE: begin
            if (accept && !a_last) begin
               state_d = ST_ROUTE;
               sel_d   = s;
            end
         end
         ST_ROUTE: begin
            if (accept && a_last) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
      stream_demux_slot #(.WIDTH(WIDTH)) u_slot (
         .clk      (clk),
         .rst_n    (rst_n),
         .load     (load[k]),
         .d        (a),
         .d_last   (a_last),
         .q        (yd[k]),
         .q_valid  (yv[k]),
         .q_last   (yl[k]),
         .q_ready  (yr[k]),
         .can_load (can_load[k])
      );
   end

   assign y0       = yd[CH_Y0];
   assign y0_valid = yv[CH_Y0];
   assign y0_last  = yl[CH_Y0];
   assign y1       = yd[CH_Y1];
   assign y1_valid = yv[CH_Y1];
   assign y1_last  = yl[CH_Y1];

`ifdef STREAM_DEMUX_STATS_EN
   logic [NUM_CH-1:0][CNT_W-1:0] cnt_q;

   // saturating: stick at all-ones rather than wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (yv[k] && yr[k] && (cnt_q[k] != {CNT_W{1'b1}}))
               cnt_q[k] <= cnt_q[k] + CNT_W'(1);
         end
      end
   end

   assign cnt0 = cnt_q[CH_Y0];
   assign cnt1 = cnt_q[CH_Y1];
`endif

endmodule

// File: doc/stream_demux.md
# stream_demux

Registered 1-to-2 stream demultiplexer: the splitting counterpart of the 2-to-1 multiplexer in our gate-level example set. One input stream with valid/ready handshake is routed beat-by-beat to one of two output channels. The select is sampled on the first beat of a packet and locked until the last beat. Each output has a one-entry register, so latency is 1 cycle and throughput is 1 beat/cycle. It sits between a single producer and two independent consumers.

## Interface
- WIDTH, 1: data width in bits of a, y0, y1.
- CNT_W, 16: width of beat counters (only used with STREAM_DEMUX_STATS_EN).
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  WIDTH  input data beat.
- a_valid  input  1  input beat present.
- a_last  input  1  final beat of packet.
- a_ready  output  1  block accepts the beat this cycle.
- s  input  1  channel select (0 -> y0, 1 -> y1), sampled on the first beat of a packet only.
- y0 / y1  output  WIDTH  channel data.
- y0_valid / y1_valid  output  1  channel holds a beat.
- y0_last / y1_last  output  1  held beat is the final beat of its packet.
- y0_ready / y1_ready  input  1  consumer accepts the channel beat.
- busy  output  1  high in the ROUTE state (mid-packet).
- cnt0 / cnt1  output  CNT_W  beats delivered per channel (STREAM_DEMUX_STATS_EN only).

## Operation
- Accept = a_valid && a_ready. Transfer out on channel k = yk_valid && yk_ready.
- Target channel: s in IDLE, locked select register sel in ROUTE.
- a_ready = !target_full || target_ready (combinational, single level of logic). The other channel's state never affects a_ready.
- FSM:
  - IDLE: accept with !a_last -> ROUTE, sel <= s. Accept with a_last -> stay IDLE (single-beat packet).
  - ROUTE: accept with a_last -> IDLE. Any other case holds the state. s is ignored.
- Channel buffer k: on accept targeting k, yk <= a, yk_last <= a_last, yk_valid <= 1. On transfer out without a load, yk_valid <= 0. Load and drain in the same cycle -> stays valid with the new beat.
- yk and yk_last are stable while yk_valid && !yk_ready.
- No beat is ever duplicated, dropped or reordered within a channel.

## Timing
- Reset (async assert, deasserted with clk): IDLE, sel=0, y0/y1=0, y0_valid/y1_valid=0, y0_last/y1_last=0, busy=0, cnt0/cnt1=0. a_ready is 1 after reset (both buffers empty).
- Latency: a beat accepted at edge N is visible on yk at N+1 with yk_valid=1.
- Throughput: 1 beat/cycle sustained when the consumer holds yk_ready=1.
- Stalled consumer: a_ready follows yk_ready of the target channel, with a_ready=0 while full and not ready.
- Reset mid-packet: buffered beats are discarded, the FSM returns to IDLE, and the next accepted beat re-samples s.
- Packet on y1 may start while y0 still holds an undrained beat of the previous packet.

## Configuration
- STREAM_DEMUX_STATS_EN defined: cnt0/cnt1 ports exist. Each counter increments on transfer out on its channel and saturates at all-ones (no wrap). Counters reset to 0 on rst_n.
- Not defined: ports and counter logic are absent. All other behaviour is identical.

## Structure
- Shared package stream_demux_pkg holds the FSM state enum (ST_IDLE, ST_ROUTE) and the channel index constants CH_Y0=0 and CH_Y1=1.
- One sub-module, stream_demux_slot: the one-entry output register with valid/last, load/drain and ready logic. It is instantiated twice. The top level holds the FSM, select lock, a_ready mux and the optional counters.

## Test plan
- Reset check: hold rst_n=0, then release -> all outputs 0, a_ready=1, busy=0.
- Single-beat packet: WIDTH=8, s=1, a=0xA5, a_last=1 -> next cycle y1=0xA5, y1_valid=1, y1_last=1, y0_valid=0, busy=0.
- Select lock: 4-beat packet 0x01..0x04 with s=0 on beat 1 and s toggled every cycle afterwards -> all four beats on y0 in order, last only on 0x04, busy high for beats 2-4.
- Backpressure: y0_ready=0 with a full y0 -> a_ready=0 and y0 held stable for 5 cycles. Raise y0_ready -> the drain and a new load occur in the same cycle with no gap.
- Independent channels: y0 stalled and full, new packet with s=1 -> accepted, delivered on y1 while y0 still holds its beat.
- Reset mid-packet plus stats: with STREAM_DEMUX_STATS_EN, deliver 3 beats on y1 -> cnt1=3. Assert rst_n mid-packet -> cnt1=0, y1_valid=0, and the next beat with s=0 routes to y0.
